// File: rtl/pic_pkg.sv
// Shared definitions for the PIC command word decoder.
// Holds the decoder state encodings, the bit positions of the ICW/OCW fields
// within a CPU write byte, the OCW2 command encodings, the read-select type,
// and a helper that recognises an ICW1 write.
package pic_pkg;

    // Decoder states. The encodings are plain constants so that older code
    // which compares against raw values keeps working.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_ICW2 = 3'd1;
    localparam logic [2:0] ST_WAIT_ICW3 = 3'd2;
    localparam logic [2:0] ST_WAIT_ICW4 = 3'd3;
    localparam logic [2:0] ST_READY     = 3'd4;

    // ICW1 fields (written with a0 = 0)
    localparam int ICW1_SEL_BIT  = 4;
    localparam int ICW1_LTIM_BIT = 3;
    localparam int ICW1_SNGL_BIT = 1;
    localparam int ICW1_IC4_BIT  = 0;

    // With a0 = 0 and bit 4 clear, bit 3 separates OCW2 (0) from OCW3 (1)
    localparam int OCW_SEL_BIT    = 3;

    // OCW3 fields
    localparam int OCW3_ESMM_BIT  = 6;
    localparam int OCW3_SMM_BIT   = 5;
    localparam int OCW3_POLL_BIT  = 2;
    localparam int OCW3_RR_BIT    = 1;
    localparam int OCW3_RIS_BIT   = 0;

    // OCW2 command encodings carried on ocw2_cmd (din[7:5])
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SPEC_EOI     = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SPEC_EOI = 3'b111;

    // Which register an a0 = 0 read returns
    typedef enum logic {
        RD_IRR = 1'b0,
        RD_ISR = 1'b1
    } rd_sel_t;

    // ICW1 is recognised in every state: a0 low with bit 4 set
    function automatic logic is_icw1(input logic a0, input logic [7:0] din);
        return (!a0) && din[ICW1_SEL_BIT];
    endfunction

endpackage

// File: rtl/cmd_word_decoder_if.sv
// CPU-side bus between the data bus buffer and the command word decoder.
//   wr_strobe, rd_strobe : one-cycle write/read pulses
//   a0                   : address bit A0, valid with either strobe
//   din                  : write data
//   dout, dout_valid     : read data and its one-cycle update pulse
// master = CPU / data bus buffer side, slave = decoder side.
interface cmd_word_decoder_if;
    logic       wr_strobe;
    logic       rd_strobe;
    logic       a0;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid;

    modport master (
        output wr_strobe, rd_strobe, a0, din,
        input  dout, dout_valid
    );

    modport slave (
        input  wr_strobe, rd_strobe, a0, din,
        output dout, dout_valid
    );
endinterface

// File: rtl/cmd_word_decoder.sv
// Command word decoder of an 8259-style interrupt controller.
// Walks the ICW1..ICW4 initialisation sequence, then decodes OCW1/2/3 and
// serves CPU register reads.
//   clk, rst          : clock and asynchronous active-high reset
//   bus               : CPU strobes, a0, write data, read data + valid pulse
//   irr, isr          : request / in-service registers for reads
//   init_done         : high while initialised (READY)
//   imr               : interrupt mask (OCW1)
//   vec_base          : ICW2[7:3]
//   icw1_ltim/sngl/ic4: ICW1 mode bits
//   cascade, icw4     : ICW3 byte, ICW4[4:0]
//   ocw2_valid/cmd/lvl: one-cycle OCW2 pulse with its command and level
//   poll_req, smm     : OCW3 poll pulse, special mask mode
module cmd_word_decoder
    import pic_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    cmd_word_decoder_if.slave         bus,
    input  logic [7:0]                irr,
    input  logic [7:0]                isr,
    output logic                      init_done,
    output logic [7:0]                imr,
    output logic [4:0]                vec_base,
    output logic                      icw1_ltim,
    output logic                      icw1_sngl,
    output logic                      icw1_ic4,
    output logic [7:0]                cascade,
    output logic [4:0]                icw4,
    output logic                      ocw2_valid,
    output logic [2:0]                ocw2_cmd,
    output logic [2:0]                ocw2_lvl,
    output logic                      poll_req,
    output logic                      smm
);

    logic [2:0] state_q,      state_d;
    logic [7:0] imr_q,        imr_d;
    logic [4:0] vec_base_q,   vec_base_d;
    logic       ltim_q,       ltim_d;
    logic       sngl_q,       sngl_d;
    logic       ic4_q,        ic4_d;
    logic [7:0] cascade_q,    cascade_d;
    logic [4:0] icw4_q,       icw4_d;
    logic       smm_q,        smm_d;
    rd_sel_t    rd_sel_q,     rd_sel_d;
    logic [7:0] dout_q,       dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       ocw2_valid_q, ocw2_valid_d;
    logic [2:0] ocw2_cmd_q,   ocw2_cmd_d;
    logic [2:0] ocw2_lvl_q,   ocw2_lvl_d;
    logic       poll_req_q,   poll_req_d;

    always_comb begin
        state_d      = state_q;
        imr_d        = imr_q;
        vec_base_d   = vec_base_q;
        ltim_d       = ltim_q;
        sngl_d       = sngl_q;
        ic4_d        = ic4_q;
        cascade_d    = cascade_q;
        icw4_d       = icw4_q;
        smm_d        = smm_q;
        rd_sel_d     = rd_sel_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        ocw2_valid_d = 1'b0;
        ocw2_cmd_d   = ocw2_cmd_q;
        ocw2_lvl_d   = ocw2_lvl_q;
        poll_req_d   = 1'b0;

        // A write always wins over a simultaneous read
        if (bus.wr_strobe) begin
            if (is_icw1(bus.a0, bus.din)) begin
                ltim_d    = bus.din[ICW1_LTIM_BIT];
                sngl_d    = bus.din[ICW1_SNGL_BIT];
                ic4_d     = bus.din[ICW1_IC4_BIT];
                imr_d     = 8'h00;
                smm_d     = 1'b0;
                cascade_d = 8'h00;
                icw4_d    = 5'h00;
                rd_sel_d  = RD_IRR;
                state_d   = ST_WAIT_ICW2;
            end else if (bus.a0) begin
                case (state_q)
                    ST_WAIT_ICW2: begin
                        vec_base_d = bus.din[7:3];
                        // ICW3 only exists in cascade mode, ICW4 only when requested
                        if (!sngl_q)     state_d = ST_WAIT_ICW3;
                        else if (ic4_q)  state_d = ST_WAIT_ICW4;
                        else             state_d = ST_READY;
                    end
                    ST_WAIT_ICW3: begin
                        cascade_d = bus.din;
                        state_d   = ic4_q ? ST_WAIT_ICW4 : ST_READY;
                    end
                    ST_WAIT_ICW4: begin
                        icw4_d  = bus.din[4:0];
                        state_d = ST_READY;
                    end
                    ST_READY: imr_d = bus.din;
                    default: ;
                endcase
            end else if (state_q == ST_READY) begin
                if (!bus.din[OCW_SEL_BIT]) begin
                    ocw2_valid_d = 1'b1;
                    ocw2_cmd_d   = bus.din[7:5];
                    ocw2_lvl_d   = bus.din[2:0];
                end else begin
                    if (bus.din[OCW3_RR_BIT])
                        rd_sel_d = rd_sel_t'(bus.din[OCW3_RIS_BIT]);
                    if (bus.din[OCW3_ESMM_BIT])
                        smm_d = bus.din[OCW3_SMM_BIT];
                    poll_req_d = bus.din[OCW3_POLL_BIT];
                end
            end
        end else if (bus.rd_strobe) begin
            dout_valid_d = 1'b1;
            // ISR is only selectable once initialised; otherwise IRR is returned
            if (bus.a0)
                dout_d = imr_q;
            else if (state_q == ST_READY && rd_sel_q == RD_ISR)
                dout_d = isr;
            else
                dout_d = irr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            imr_q        <= 8'h00;
            vec_base_q   <= 5'h00;
            ltim_q       <= 1'b0;
            sngl_q       <= 1'b0;
            ic4_q        <= 1'b0;
            cascade_q    <= 8'h00;
            icw4_q       <= 5'h00;
            smm_q        <= 1'b0;
            rd_sel_q     <= RD_IRR;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
            ocw2_valid_q <= 1'b0;
            ocw2_cmd_q   <= 3'b000;
            ocw2_lvl_q   <= 3'b000;
            poll_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            imr_q        <= imr_d;
            vec_base_q   <= vec_base_d;
            ltim_q       <= ltim_d;
            sngl_q       <= sngl_d;
            ic4_q        <= ic4_d;
            cascade_q    <= cascade_d;
            icw4_q       <= icw4_d;
            smm_q        <= smm_d;
            rd_sel_q     <= rd_sel_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ocw2_valid_q <= ocw2_valid_d;
            ocw2_cmd_q   <= ocw2_cmd_d;
            ocw2_lvl_q   <= ocw2_lvl_d;
            poll_req_q   <= poll_req_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign init_done      = (state_q == ST_READY);
    assign imr            = imr_q;
    assign vec_base       = vec_base_q;
    assign icw1_ltim      = ltim_q;
    assign icw1_sngl      = sngl_q;
    assign icw1_ic4       = ic4_q;
    assign cascade        = cascade_q;
    assign icw4           = icw4_q;
    assign smm            = smm_q;
    assign ocw2_valid     = ocw2_valid_q;
    assign ocw2_cmd       = ocw2_cmd_q;
    assign ocw2_lvl       = ocw2_lvl_q;
    assign poll_req       = poll_req_q;

endmodule

// File: tb/tb_cmd_word_decoder.sv
// Self-checking bench for cmd_word_decoder: directed scenarios with constant
// expectations followed by random traffic checked against a reference model
// that tracks the initialisation sequence as a list of still-expected ICWs.
module tb_cmd_word_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] irr;
    logic [7:0] isr;
    logic       init_done;
    logic [7:0] imr;
    logic [4:0] vec_base;
    logic       icw1_ltim, icw1_sngl, icw1_ic4;
    logic [7:0] cascade;
    logic [4:0] icw4;
    logic       ocw2_valid;
    logic [2:0] ocw2_cmd, ocw2_lvl;
    logic       poll_req, smm;

    cmd_word_decoder_if bus_if ();

    cmd_word_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .irr        (irr),
        .isr        (isr),
        .init_done  (init_done),
        .imr        (imr),
        .vec_base   (vec_base),
        .icw1_ltim  (icw1_ltim),
        .icw1_sngl  (icw1_sngl),
        .icw1_ic4   (icw1_ic4),
        .cascade    (cascade),
        .icw4       (icw4),
        .ocw2_valid (ocw2_valid),
        .ocw2_cmd   (ocw2_cmd),
        .ocw2_lvl   (ocw2_lvl),
        .poll_req   (poll_req),
        .smm        (smm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: 'started' means an ICW1 has been seen since reset,
    // 'pending' lists the ICW numbers still owed before initialisation ends.
    bit       m_started;
    int       pending[$];
    bit       m_ltim, m_sngl, m_ic4, m_smm, m_isr_sel;
    bit [7:0] m_imr, m_cas, m_dout;
    bit [4:0] m_vec, m_icw4;
    bit [2:0] m_cmd, m_lvl;
    bit       m_dv, m_o2v, m_poll;

    function automatic bit m_ready();
        return m_started && (pending.size() == 0);
    endfunction

    task automatic model_reset();
        m_started = 0; pending.delete();
        m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_smm = 0; m_isr_sel = 0;
        m_imr = 0; m_cas = 0; m_dout = 0; m_vec = 0; m_icw4 = 0;
        m_cmd = 0; m_lvl = 0; m_dv = 0; m_o2v = 0; m_poll = 0;
    endtask

    task automatic model_step(input bit w, input bit r, input bit a, input bit [7:0] d,
                              input bit [7:0] ir, input bit [7:0] is);
        int k;
        m_dv = 0; m_o2v = 0; m_poll = 0;
        if (w) begin
            if (!a && d[4]) begin
                m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
                m_imr = 0; m_smm = 0; m_cas = 0; m_icw4 = 0; m_isr_sel = 0;
                m_started = 1;
                pending.delete();
                pending.push_back(2);
                if (!m_sngl) pending.push_back(3);
                if (m_ic4)   pending.push_back(4);
            end else if (a) begin
                if (m_started && pending.size() > 0) begin
                    k = pending.pop_front();
                    if (k == 2)      m_vec  = d[7:3];
                    else if (k == 3) m_cas  = d;
                    else             m_icw4 = d[4:0];
                end else if (m_ready()) begin
                    m_imr = d;
                end
            end else if (m_ready()) begin
                if (d[3] == 0) begin
                    m_o2v = 1; m_cmd = d[7:5]; m_lvl = d[2:0];
                end else begin
                    if (d[1]) m_isr_sel = d[0];
                    if (d[6]) m_smm = d[5];
                    m_poll = d[2];
                end
            end
        end else if (r) begin
            m_dv = 1;
            if (a)                         m_dout = m_imr;
            else if (m_ready() && m_isr_sel) m_dout = is;
            else                           m_dout = ir;
        end
    endtask

    // Starts at a falling edge: drive, let one rising edge pass, sample at
    // the next falling edge with the strobes released.
    task automatic drive_cycle(input bit w, input bit r, input bit a, input bit [7:0] d);
        bus_if.wr_strobe = w;
        bus_if.rd_strobe = r;
        bus_if.a0        = a;
        bus_if.din       = d;
        model_step(w, r, a, d, irr, isr);
        @(negedge clk);
        bus_if.wr_strobe = 1'b0;
        bus_if.rd_strobe = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #3;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #2;
        vectors++;
        if ({init_done, imr, vec_base, icw1_ltim, icw1_sngl, icw1_ic4, cascade, icw4, smm} !== 31'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_regs: got %h expected 0",
                     {init_done, imr, vec_base, icw1_ltim, icw1_sngl, icw1_ic4, cascade, icw4, smm});
        end
        vectors++;
        if ({bus_if.dout, bus_if.dout_valid, ocw2_valid, poll_req, ocw2_cmd, ocw2_lvl} !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_pulses: got %h expected 0",
                     {bus_if.dout, bus_if.dout_valid, ocw2_valid, poll_req, ocw2_cmd, ocw2_lvl});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_no_icw4();
        drive_cycle(1, 0, 0, 8'h12);
        vectors++;
        if (init_done !== 1'b0 || icw1_sngl !== 1'b1 || icw1_ic4 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_icw1: got init=%b sngl=%b ic4=%b expected 0 1 0",
                     init_done, icw1_sngl, icw1_ic4);
        end
        drive_cycle(1, 0, 1, 8'h40);
        vectors++;
        if (init_done !== 1'b1 || vec_base !== 5'h08 || icw4 !== 5'h00) begin
            miscompares++;
            $display("[TB] FAIL single_icw2: got init=%b vec=%h icw4=%h expected 1 08 00",
                     init_done, vec_base, icw4);
        end
    endtask

    task automatic test_cascade_icw4();
        drive_cycle(1, 0, 0, 8'h11);
        drive_cycle(1, 0, 1, 8'h20);
        vectors++;
        if (init_done !== 1'b0 || vec_base !== 5'h04) begin
            miscompares++;
            $display("[TB] FAIL cascade_icw2: got init=%b vec=%h expected 0 04", init_done, vec_base);
        end
        drive_cycle(1, 0, 1, 8'h04);
        vectors++;
        if (init_done !== 1'b0 || cascade !== 8'h04) begin
            miscompares++;
            $display("[TB] FAIL cascade_icw3: got init=%b cas=%h expected 0 04", init_done, cascade);
        end
        drive_cycle(1, 0, 1, 8'h03);
        vectors++;
        if (init_done !== 1'b1 || cascade !== 8'h04 || icw4 !== 5'h03) begin
            miscompares++;
            $display("[TB] FAIL cascade_icw4: got init=%b cas=%h icw4=%h expected 1 04 03",
                     init_done, cascade, icw4);
        end
    endtask

    task automatic test_ocw1_read();
        drive_cycle(1, 0, 1, 8'hA5);
        vectors++;
        if (imr !== 8'hA5 || bus_if.dout_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ocw1_write: got imr=%h dv=%b expected a5 0", imr, bus_if.dout_valid);
        end
        drive_cycle(0, 1, 1, 8'h00);
        vectors++;
        if (bus_if.dout !== 8'hA5 || bus_if.dout_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ocw1_read: got dout=%h dv=%b expected a5 1", bus_if.dout, bus_if.dout_valid);
        end
        drive_cycle(0, 0, 0, 8'h00);
        vectors++;
        if (bus_if.dout_valid !== 1'b0 || bus_if.dout !== 8'hA5) begin
            miscompares++;
            $display("[TB] FAIL read_pulse_end: got dv=%b dout=%h expected 0 a5", bus_if.dout_valid, bus_if.dout);
        end
    endtask

    task automatic test_ocw3_read_select();
        isr = 8'h10; irr = 8'h01;
        drive_cycle(1, 0, 0, 8'h0B);
        drive_cycle(0, 1, 0, 8'h00);
        vectors++;
        if (bus_if.dout !== 8'h10 || bus_if.dout_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read_isr: got dout=%h dv=%b expected 10 1", bus_if.dout, bus_if.dout_valid);
        end
        drive_cycle(1, 0, 0, 8'h0A);
        drive_cycle(0, 1, 0, 8'h00);
        vectors++;
        if (bus_if.dout !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL read_irr: got dout=%h expected 01", bus_if.dout);
        end
        drive_cycle(1, 0, 0, 8'h68);
        vectors++;
        if (smm !== 1'b1 || poll_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL smm_set: got smm=%b poll=%b expected 1 0", smm, poll_req);
        end
    endtask

    task automatic test_ocw2_poll();
        drive_cycle(1, 0, 0, 8'h20);
        vectors++;
        if (ocw2_valid !== 1'b1 || ocw2_cmd !== 3'b001 || ocw2_lvl !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL ocw2_pulse: got v=%b cmd=%b lvl=%b expected 1 001 000",
                     ocw2_valid, ocw2_cmd, ocw2_lvl);
        end
        drive_cycle(0, 0, 0, 8'h00);
        vectors++;
        if (ocw2_valid !== 1'b0 || ocw2_cmd !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL ocw2_hold: got v=%b cmd=%b expected 0 001", ocw2_valid, ocw2_cmd);
        end
        drive_cycle(1, 0, 0, 8'h0C);
        vectors++;
        if (poll_req !== 1'b1 || ocw2_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL poll_pulse: got poll=%b o2v=%b expected 1 0", poll_req, ocw2_valid);
        end
        drive_cycle(0, 0, 0, 8'h00);
        vectors++;
        if (poll_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL poll_end: got poll=%b expected 0", poll_req);
        end
    endtask

    task automatic test_back_to_back();
        // Simultaneous strobes: the write lands, the read is dropped
        drive_cycle(1, 1, 1, 8'h3C);
        vectors++;
        if (imr !== 8'h3C || bus_if.dout_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_rd_collide: got imr=%h dv=%b expected 3c 0", imr, bus_if.dout_valid);
        end
        // Select ISR, then restart init: a0=0 reads must return IRR again
        isr = 8'h80; irr = 8'h02;
        drive_cycle(1, 0, 0, 8'h0B);
        drive_cycle(1, 0, 0, 8'h13);
        drive_cycle(1, 0, 0, 8'h20);
        vectors++;
        if (ocw2_valid !== 1'b0 || init_done !== 1'b0 || imr !== 8'h00 || smm !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ignored_ocw_in_wait: got o2v=%b init=%b imr=%h smm=%b expected 0 0 00 0",
                     ocw2_valid, init_done, imr, smm);
        end
        drive_cycle(0, 1, 0, 8'h00);
        vectors++;
        if (bus_if.dout !== 8'h02 || bus_if.dout_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read_irr_not_ready: got dout=%h dv=%b expected 02 1", bus_if.dout, bus_if.dout_valid);
        end
    endtask

    task automatic test_reset_abort();
        drive_cycle(1, 0, 0, 8'h11);
        drive_cycle(1, 0, 1, 8'h20);
        apply_reset();
        drive_cycle(1, 0, 1, 8'h55);
        vectors++;
        if (init_done !== 1'b0 || cascade !== 8'h00 || imr !== 8'h00 || vec_base !== 5'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_abort: got init=%b cas=%h imr=%h vec=%h expected 0 00 00 00",
                     init_done, cascade, imr, vec_base);
        end
    endtask

    task automatic test_random();
        int r;
        bit w, rd, a;
        bit [7:0] d;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            w = 0; rd = 0; a = $urandom_range(0, 1); d = 8'($urandom);
            irr = 8'($urandom); isr = 8'($urandom);
            if (r < 8)       begin w = 1; a = 0; d[4] = 1'b1; end
            else if (r < 40) begin w = 1; a = 1; end
            else if (r < 60) begin w = 1; a = 0; d[4] = 1'b0; end
            else if (r < 85) rd = 1;
            else if (r < 90) begin w = 1; rd = 1; if (!a) d[4] = 1'b0; end
            drive_cycle(w, rd, a, d);
            vectors++;
            if ({init_done, imr, vec_base, icw1_ltim, icw1_sngl, icw1_ic4, cascade, icw4, smm} !==
                {m_ready(), m_imr, m_vec, m_ltim, m_sngl, m_ic4, m_cas, m_icw4, m_smm}) begin
                miscompares++;
                $display("[TB] FAIL rand_regs cycle %0d: got %h expected %h", i,
                         {init_done, imr, vec_base, icw1_ltim, icw1_sngl, icw1_ic4, cascade, icw4, smm},
                         {m_ready(), m_imr, m_vec, m_ltim, m_sngl, m_ic4, m_cas, m_icw4, m_smm});
            end
            vectors++;
            if ({bus_if.dout_valid, ocw2_valid, poll_req} !== {m_dv, m_o2v, m_poll}) begin
                miscompares++;
                $display("[TB] FAIL rand_pulses cycle %0d: got %b expected %b", i,
                         {bus_if.dout_valid, ocw2_valid, poll_req}, {m_dv, m_o2v, m_poll});
            end
            vectors++;
            if ({bus_if.dout, ocw2_cmd, ocw2_lvl} !== {m_dout, m_cmd, m_lvl}) begin
                miscompares++;
                $display("[TB] FAIL rand_data cycle %0d: got %h expected %h", i,
                         {bus_if.dout, ocw2_cmd, ocw2_lvl}, {m_dout, m_cmd, m_lvl});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        irr = 8'h00; isr = 8'h00;
        bus_if.wr_strobe = 1'b0;
        bus_if.rd_strobe = 1'b0;
        bus_if.a0        = 1'b0;
        bus_if.din       = 8'h00;
        model_reset();
        test_reset();
        test_single_no_icw4();
        test_cascade_icw4();
        test_ocw1_read();
        test_ocw3_read_select();
        test_ocw2_poll();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
